// File: rtl/lsa_mem_loader.sv
// Serial boot loader: receives a framed image on an 8N1 UART line and writes
// 16-bit words onto the lsa memory bus while holding lsa_core in reset.
module lsa_mem_loader #(
  parameter int CLKS_PER_BIT = 208,
  parameter bit BOOT_HOLD    = 1'b1
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        uart_rx,
  output logic [15:0] mem_add,
  output logic [15:0] mem_out,
  output logic        mem_we,
  output logic        mem_fetch,
  output logic        mem_oe,
  output logic        core_reset_out,
  output logic        loader_busy,
  output logic        loader_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    HUNT, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CSUM
  } ld_state_t;

  rx_state_t   rx_state, rx_next;
  ld_state_t   ld_state, ld_next;
  logic        rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_byte;
  logic        byte_valid, frame_err;
  logic        tick_half, tick_full;
  logic [15:0] addr, count;
  logic [7:0]  data_hi, csum;

  assign mem_fetch = 1'b0;
  assign mem_oe    = 1'b0;
  assign tick_half = (bit_cnt == HALF);
  assign tick_full = (bit_cnt == FULL);

  // Receiver next state; a start edge that is high again at mid-bit is a glitch.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_s3 && !rx_s2) rx_next = RX_START;
      RX_START: if (tick_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (tick_full) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_s3      <= 1'b1;
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      rx_s3      <= rx_s2;
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || rx_next != rx_state || tick_full)
        bit_cnt <= '0;
      else
        bit_cnt <= bit_cnt + 1'b1;
      if (rx_state == RX_DATA && tick_full) begin
        rx_byte <= {rx_s2, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (rx_state == RX_STOP && tick_full) begin
        byte_valid <= rx_s2;
        frame_err  <= !rx_s2;
      end
    end
  end

  always_comb begin
    ld_next = ld_state;
    if (frame_err) ld_next = HUNT;
    else begin
      case (ld_state)
        HUNT:    if (byte_valid && rx_byte == 8'h4C) ld_next = ADDR_HI;
        ADDR_HI: if (byte_valid) ld_next = ADDR_LO;
        ADDR_LO: if (byte_valid) ld_next = CNT_HI;
        CNT_HI:  if (byte_valid) ld_next = CNT_LO;
        CNT_LO:  if (byte_valid) ld_next = ({count[15:8], rx_byte} == 16'd0) ? CSUM : DATA_HI;
        DATA_HI: if (byte_valid) ld_next = DATA_LO;
        DATA_LO: if (byte_valid) ld_next = WRITE;
        WRITE:   ld_next = (count == 16'd1) ? CSUM : DATA_HI;
        CSUM:    if (byte_valid) ld_next = HUNT;
        default: ld_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      ld_state       <= HUNT;
      addr           <= '0;
      count          <= '0;
      data_hi        <= '0;
      csum           <= '0;
      mem_we         <= 1'b0;
      mem_add        <= '0;
      mem_out        <= '0;
      core_reset_out <= BOOT_HOLD;
      loader_busy    <= 1'b0;
      loader_error   <= 1'b0;
    end else begin
      ld_state <= ld_next;
      mem_we   <= 1'b0;
      if (frame_err) begin
        loader_error <= 1'b1;
        loader_busy  <= 1'b0;
      end else begin
        case (ld_state)
          HUNT: if (byte_valid && rx_byte == 8'h4C) begin
            core_reset_out <= 1'b1;
            loader_busy    <= 1'b1;
            loader_error   <= 1'b0;
            csum           <= '0;
          end
          ADDR_HI: if (byte_valid) addr[15:8]  <= rx_byte;
          ADDR_LO: if (byte_valid) addr[7:0]   <= rx_byte;
          CNT_HI:  if (byte_valid) count[15:8] <= rx_byte;
          CNT_LO:  if (byte_valid) count[7:0]  <= rx_byte;
          DATA_HI: if (byte_valid) begin
            data_hi <= rx_byte;
            csum    <= csum + rx_byte;
          end
          // Bus outputs are loaded here so the strobe is a clean register.
          DATA_LO: if (byte_valid) begin
            csum    <= csum + rx_byte;
            mem_we  <= 1'b1;
            mem_add <= addr;
            mem_out <= {data_hi, rx_byte};
          end
          WRITE: begin
            addr  <= addr + 16'd1;
            count <= count - 16'd1;
          end
          CSUM: if (byte_valid) begin
            loader_busy <= 1'b0;
            if (rx_byte == csum) core_reset_out <= 1'b0;
            else                 loader_error   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_lsa_mem_loader.sv
// Scoreboard bench for lsa_mem_loader: expected writes are queued as frames
// are sent and matched against every mem_we pulse.
module tb_lsa_mem_loader;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        uart_rx;
  logic [15:0] mem_add, mem_out;
  logic        mem_we, mem_fetch, mem_oe;
  logic        core_reset_out, loader_busy, loader_error;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] wbuf[8];

  always #5 clk = ~clk;

  lsa_mem_loader #(.CLKS_PER_BIT(CPB), .BOOT_HOLD(1'b1)) dut (
    .clock_in(clk), .reset_in(reset_in), .uart_rx(uart_rx),
    .mem_add(mem_add), .mem_out(mem_out), .mem_we(mem_we),
    .mem_fetch(mem_fetch), .mem_oe(mem_oe),
    .core_reset_out(core_reset_out), .loader_busy(loader_busy),
    .loader_error(loader_error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (exp_q.size() == 0) chk("we_unexpected", {mem_add, mem_out}, 32'hx);
      else chk("write", {mem_add, mem_out}, exp_q.pop_front());
    end
    if (mem_fetch || mem_oe) chk("fetch_oe", {30'd0, mem_fetch, mem_oe}, 32'd0);
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    uart_rx = b;
    cycles(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    uart_rx = 1'b1;
    cycles(3);
  endtask

  task automatic send_frame(input logic [15:0] addr, input int n, input bit bad_cs);
    logic [7:0]  cs;
    logic [15:0] a;
    logic [15:0] cnt;
    cs  = 8'h00;
    a   = addr;
    cnt = 16'(n);
    send_byte(8'h4C, 1'b1);
    send_byte(addr[15:8], 1'b1);
    send_byte(addr[7:0], 1'b1);
    send_byte(cnt[15:8], 1'b1);
    send_byte(cnt[7:0], 1'b1);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({a, wbuf[i]});
      a  = a + 16'd1;
      cs = cs + wbuf[i][15:8] + wbuf[i][7:0];
      send_byte(wbuf[i][15:8], 1'b1);
      send_byte(wbuf[i][7:0], 1'b1);
    end
    send_byte(bad_cs ? cs + 8'd1 : cs, 1'b1);
    cycles(10);
  endtask

  task automatic status(input string tag, input logic core, input logic busy, input logic err);
    @(negedge clk);
    chk({tag, "_core"}, {31'd0, core_reset_out}, {31'd0, core});
    chk({tag, "_busy"}, {31'd0, loader_busy}, {31'd0, busy});
    chk({tag, "_err"},  {31'd0, loader_error}, {31'd0, err});
    #1;
  endtask

  initial begin
    uart_rx  = 1'b1;
    reset_in = 1'b1;
    cycles(2);
    @(negedge clk);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_add_out", {mem_add, mem_out}, 32'd0);
    status("rst", 1'b1, 1'b0, 1'b0);
    reset_in = 1'b0;
    cycles(5);

    // basic load: checksum = 12+34+AB+CD mod 256 = BE
    wbuf[0] = 16'h1234; wbuf[1] = 16'hABCD;
    send_frame(16'h0100, 2, 1'b0);
    status("basic", 1'b0, 1'b0, 1'b0);
    chk("basic_sb", exp_q.size(), 32'd0);

    send_frame(16'h0100, 2, 1'b1);
    status("badcs", 1'b1, 1'b0, 1'b1);
    chk("badcs_sb", exp_q.size(), 32'd0);
    chk("hold_bus", {mem_add, mem_out}, 32'h0101ABCD);

    send_frame(16'h0010, 0, 1'b0);
    status("zero", 1'b0, 1'b0, 1'b0);

    wbuf[0] = 16'h0001; wbuf[1] = 16'h0002;
    send_frame(16'hFFFF, 2, 1'b0);
    status("wrap", 1'b0, 1'b0, 1'b0);
    chk("wrap_sb", exp_q.size(), 32'd0);

    // glitch mid-frame: a phantom 0xFF byte would corrupt the write
    send_byte(8'h4C, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
    status("hdr", 1'b1, 1'b1, 1'b0);
    uart_rx = 1'b0;
    cycles(1);
    uart_rx = 1'b1;
    cycles(60);
    exp_q.push_back({16'h0020, 16'h5566});
    send_byte(8'h55, 1'b1); send_byte(8'h66, 1'b1); send_byte(8'hBB, 1'b1);
    cycles(10);
    status("glitch", 1'b0, 1'b0, 1'b0);
    chk("glitch_sb", exp_q.size(), 32'd0);

    // framing error mid-frame, then a fresh header recovers
    send_byte(8'h4C, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h30, 1'b1);
    send_byte(8'h00, 1'b0);
    cycles(5);
    status("ferr", 1'b1, 1'b0, 1'b1);
    send_byte(8'h4C, 1'b1);
    status("rehdr", 1'b1, 1'b1, 1'b0);
    exp_q.push_back({16'h0040, 16'h1122});
    send_byte(8'h00, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h11, 1'b1); send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    cycles(10);
    status("refr", 1'b0, 1'b0, 1'b0);
    chk("refr_sb", exp_q.size(), 32'd0);

    // reset after the first data byte: no writes may follow
    send_byte(8'h4C, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h12, 1'b1);
    reset_in = 1'b1;
    cycles(2);
    reset_in = 1'b0;
    status("midrst", 1'b1, 1'b0, 1'b0);
    send_byte(8'h34, 1'b1); send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    send_byte(8'hBE, 1'b1);
    cycles(10);
    status("after_rst", 1'b1, 1'b0, 1'b0);
    chk("midrst_sb", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
